// File: rtl/mult_arbiter.sv
// Round-robin arbiter that shares one sequential W x W multiplier among NREQ requesters.
// One job is in flight at a time: grant, capture operands, launch, wait (bounded), return product.
module mult_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 8,
    parameter int MIN_LAT = 2,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] op_a,
    input  logic [NREQ*W-1:0] op_b,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   done,
    output logic [2*W-1:0]    res_out,
    output logic              busy,
    output logic              err,
    output logic [W-1:0]      mult_a,
    output logic [W-1:0]      mult_b,
    output logic              mult_en,
    input  logic [2*W-1:0]    mult_res,
    input  logic              mult_ready
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_GRANT  = 3'd1;
    localparam logic [2:0] S_LAUNCH = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]      state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   gnt;
    logic [IW-1:0]   sel;
    logic [IW-1:0]   gnt_next;
    logic            sel_found;
    logic [NREQ-1:0] sel_oh;
    logic [NREQ-1:0] gnt_oh;
    logic [CW-1:0]   cnt;

    // Pick the first high request at or after ptr, wrapping modulo NREQ.
    always_comb begin
        int idx;
        idx       = 0;
        sel_found = 1'b0;
        sel       = ptr;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!sel_found && req[idx]) begin
                sel_found = 1'b1;
                sel       = idx[IW-1:0];
            end
        end
    end

    always_comb begin
        sel_oh      = '0;
        sel_oh[sel] = 1'b1;
        gnt_oh      = '0;
        gnt_oh[gnt] = 1'b1;
    end

    assign gnt_next = (int'(gnt) == NREQ - 1) ? '0 : gnt + 1'b1;
    assign busy     = (state != S_IDLE);

    // Main FSM; ack, done and mult_en are single-cycle pulses cleared by default every cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            ptr     <= '0;
            gnt     <= '0;
            cnt     <= '0;
            ack     <= '0;
            done    <= '0;
            res_out <= '0;
            err     <= 1'b0;
            mult_a  <= '0;
            mult_b  <= '0;
            mult_en <= 1'b0;
        end else begin
            ack     <= '0;
            done    <= '0;
            mult_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (sel_found) begin
                        gnt   <= sel;
                        ack   <= sel_oh;
                        state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    mult_a  <= op_a[int'(gnt)*W +: W];
                    mult_b  <= op_b[int'(gnt)*W +: W];
                    mult_en <= 1'b1;
                    state   <= S_LAUNCH;
                end
                S_LAUNCH: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    cnt <= cnt + 1'b1;
                    // The MIN_LAT guard ignores the stale ready level left over from the previous job.
                    if (cnt >= CW'(MIN_LAT) && mult_ready) begin
                        res_out <= mult_res;
                        done    <= gnt_oh;
                        state   <= S_DONE;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        err   <= 1'b1;
                        ptr   <= gnt_next;
                        state <= S_IDLE;
                    end
                end
                S_DONE: begin
                    ptr   <= gnt_next;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter: a round-robin reference plans the expected job order,
// a monitor pops and compares on every ack / mult_en / done / err event.
module tb_mult_arbiter;
    localparam int NREQ    = 4;
    localparam int W       = 8;
    localparam int MIN_LAT = 2;
    localparam int TIMEOUT = 64;

    typedef struct {
        int idx;
        int a;
        int b;
        bit tmo;
    } job_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] op_a;
    logic [NREQ*W-1:0] op_b;
    logic [NREQ-1:0]   ack;
    logic [NREQ-1:0]   done;
    logic [2*W-1:0]    res_out;
    logic              busy;
    logic              err;
    logic [W-1:0]      mult_a;
    logic [W-1:0]      mult_b;
    logic              mult_en;
    logic [2*W-1:0]    mult_res;
    logic              mult_ready;

    job_t expq[$];
    job_t cur;
    int   model_ptr = 0;
    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    int   en_cyc    = 0;
    int   en_count  = 0;
    logic err_q     = 1'b0;
    logic stall     = 1'b0;

    logic           m_ready;
    logic [2*W-1:0] m_res;
    logic [2*W-1:0] m_pend;
    int             m_cnt;

    mult_arbiter #(.NREQ(NREQ), .W(W), .MIN_LAT(MIN_LAT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b),
        .ack(ack), .done(done), .res_out(res_out), .busy(busy), .err(err),
        .mult_a(mult_a), .mult_b(mult_b), .mult_en(mult_en),
        .mult_res(mult_res), .mult_ready(mult_ready)
    );

    always #5 clk = ~clk;

    // Sequential multiplier stand-in with a random 1..6 cycle latency.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ready <= 1'b1;
            m_res   <= '0;
            m_pend  <= '0;
            m_cnt   <= 0;
        end else if (mult_en) begin
            m_ready <= 1'b0;
            m_pend  <= (2*W)'(mult_a) * (2*W)'(mult_b);
            m_cnt   <= int'($urandom_range(6, 1));
        end else if (!m_ready) begin
            if (m_cnt <= 1) begin
                m_ready <= 1'b1;
                m_res   <= m_pend;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end
    assign mult_res   = m_res;
    assign mult_ready = m_ready && !stall;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic setOperands(input int i, input int a, input int b);
        op_a[i*W +: W] = W'(a);
        op_b[i*W +: W] = W'(b);
    endtask

    // Reference round-robin: serve the first pending requester at or after the pointer.
    task automatic planJobs(input logic [NREQ-1:0] mask, input int njobs, input bit held, input bit tmo);
        logic [NREQ-1:0] m;
        int   g;
        job_t j;
        m = mask;
        for (int n = 0; n < njobs; n++) begin
            g = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (g < 0 && m[(model_ptr + k) % NREQ]) g = (model_ptr + k) % NREQ;
            end
            j.idx = g;
            j.a   = int'(op_a[g*W +: W]);
            j.b   = int'(op_b[g*W +: W]);
            j.tmo = tmo;
            expq.push_back(j);
            model_ptr = (g + 1) % NREQ;
            if (!held) m[g] = 1'b0;
        end
    endtask

    task automatic waitJobs(input int njobs, input bit held);
        int   served;
        logic err_prev;
        served   = 0;
        err_prev = err;
        for (int c = 0; c < 200 * njobs + 100 && served < njobs; c++) begin
            @(negedge clk);
            if (!held) req = req & ~ack;
            if (done != '0 || (err && !err_prev)) served++;
            err_prev = err;
            if (served == njobs) req = '0;
        end
        req = '0;
        checkOutput("jobs_completed", 32'(served), 32'(njobs));
        repeat (2) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] mask, input bit held, input int njobs, input bit tmo);
        planJobs(mask, njobs, held, tmo);
        req = mask;
        waitJobs(njobs, held);
    endtask

    // Monitor: every DUT event is compared against the head of the expected-job queue.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            checkOutput("ack_done_excl", 32'(ack & done), 0);
            if (ack != '0) begin
                if (expq.size() == 0) checkOutput("ack_without_job", 32'(ack), 0);
                else checkOutput("ack_index", 32'(ack), 32'(1) << expq[0].idx);
                en_count = 0;
            end
            if (mult_en) begin
                en_count++;
                en_cyc = cyc;
                if (expq.size() == 0) checkOutput("en_without_job", 32'(mult_en), 0);
                else begin
                    checkOutput("mult_a", 32'(mult_a), expq[0].a);
                    checkOutput("mult_b", 32'(mult_b), expq[0].b);
                end
            end
            if (done != '0) begin
                if (expq.size() == 0) checkOutput("done_without_job", 32'(done), 0);
                else begin
                    cur = expq.pop_front();
                    if (cur.tmo) checkOutput("done_on_timeout_job", 32'(done), 0);
                    else begin
                        checkOutput("done_index", 32'(done), 32'(1) << cur.idx);
                        checkOutput("res_out", 32'(res_out), cur.a * cur.b);
                        checkOutput("en_per_job", en_count, 1);
                    end
                end
            end
            if (err && !err_q) begin
                if (expq.size() == 0) checkOutput("err_without_job", 32'(err), 0);
                else begin
                    cur = expq.pop_front();
                    if (!cur.tmo) checkOutput("err_on_normal_job", 32'(err), 0);
                    else begin
                        checkOutput("timeout_cycles", cyc - en_cyc, TIMEOUT + 1);
                        checkOutput("timeout_en_count", en_count, 1);
                    end
                end
            end
        end
        err_q = err;
    end

    initial begin
        int   mask;
        int   waited;
        req  = '0;
        op_a = '0;
        op_b = '0;
        rst  = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_ack", 32'(ack), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_err", 32'(err), 0);
        checkOutput("rst_mult_en", 32'(mult_en), 0);
        checkOutput("rst_res_out", 32'(res_out), 0);

        $display("[TB] all requesters from reset");
        for (int i = 0; i < NREQ; i++) setOperands(i, i + 1, 5);
        planJobs(4'hF, 4, 1'b0, 1'b0);
        req = 4'hF;
        rst = 1'b1;
        waitJobs(4, 1'b0);
        checkOutput("t3_last_res", 32'(res_out), 20);

        $display("[TB] single request latency");
        setOperands(0, 5, 1);
        planJobs(4'b0001, 1, 1'b0, 1'b0);
        req = 4'b0001;
        @(negedge clk);
        checkOutput("t1_ack_latency", 32'(ack), 1);
        req = '0;
        @(negedge clk);
        checkOutput("t1_en_latency", 32'(mult_en), 1);
        waitJobs(1, 1'b0);
        checkOutput("t1_res", 32'(res_out), 5);

        $display("[TB] boundary operands");
        setOperands(1, 39, 255);
        applyStimulus(4'b0010, 1'b0, 1, 1'b0);
        checkOutput("t2_res_a", 32'(res_out), 9945);
        setOperands(2, 255, 255);
        applyStimulus(4'b0100, 1'b0, 1, 1'b0);
        checkOutput("t2_res_b", 32'(res_out), 65025);

        $display("[TB] held requests share fairly");
        setOperands(0, 7, 9);
        setOperands(3, 11, 13);
        applyStimulus(4'b1001, 1'b1, 6, 1'b0);

        $display("[TB] random request sets");
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < NREQ; i++) setOperands(i, int'($urandom_range(255)), int'($urandom_range(255)));
            mask = int'($urandom_range(15, 1));
            applyStimulus(NREQ'(mask), 1'b0, $countones(NREQ'(mask)), 1'b0);
        end

        $display("[TB] multiplier never ready");
        stall = 1'b1;
        setOperands(2, 3, 4);
        applyStimulus(4'b0100, 1'b0, 1, 1'b1);
        checkOutput("t5_err", 32'(err), 1);
        checkOutput("t5_idle", 32'(busy), 0);
        stall = 1'b0;
        setOperands(3, 12, 12);
        applyStimulus(4'b1000, 1'b0, 1, 1'b0);
        checkOutput("t5_next_res", 32'(res_out), 144);

        $display("[TB] reset during wait");
        setOperands(1, 16, 5);
        planJobs(4'b0010, 1, 1'b0, 1'b0);
        req    = 4'b0010;
        waited = 0;
        while (!mult_en && waited < 20) begin
            @(negedge clk);
            req = req & ~ack;
            waited++;
        end
        checkOutput("t6_launch_seen", 32'(mult_en), 1);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        expq.delete();
        model_ptr = 0;
        req       = '0;
        checkOutput("t6_busy", 32'(busy), 0);
        checkOutput("t6_err", 32'(err), 0);
        checkOutput("t6_res_out", 32'(res_out), 0);
        checkOutput("t6_mult_a", 32'(mult_a), 0);
        checkOutput("t6_mult_b", 32'(mult_b), 0);
        checkOutput("t6_mult_en", 32'(mult_en), 0);
        checkOutput("t6_ack_done", 32'({ack, done}), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        setOperands(1, 5, 16);
        applyStimulus(4'b0010, 1'b0, 1, 1'b0);
        checkOutput("t6_res_after", 32'(res_out), 80);
        checkOutput("queue_drained", expq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
